// File: rtl/dice_roll_scheduler_pkg.sv
// Shared definitions for the dice roll scheduler: FSM states and the legal throw range.
package dice_roll_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROLL,
    ST_SETTLE,
    ST_CAPTURE
  } state_t;

  localparam logic [2:0] THROW_MIN = 3'd1;
  localparam logic [2:0] THROW_MAX = 3'd6;

  function automatic logic throw_legal(input logic [2:0] t);
    return (t >= THROW_MIN) && (t <= THROW_MAX);
  endfunction

endpackage

// File: rtl/dice_roll_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set req at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_PLAYERS = 4,
  localparam int unsigned PW = $clog2(N_PLAYERS)
) (
  input  logic [N_PLAYERS-1:0] req,
  input  logic [PW-1:0]        rr_ptr,
  output logic [N_PLAYERS-1:0] grant,
  output logic [PW-1:0]        index,
  output logic                 any
);

  always_comb begin
    logic [PW-1:0] c;
    any   = 1'b0;
    index = '0;
    grant = '0;
    c     = '0;
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      c = PW'((32'(rr_ptr) + i) % N_PLAYERS);
      if (!any && req[c]) begin
        any   = 1'b1;
        index = c;
      end
    end
    if (any) grant[index] = 1'b1;
  end

endmodule

// File: rtl/dice_roll_scheduler.sv
// Shares one dice between N players: round-robin grant, timed button press, settle,
// capture with bounded re-rolls on illegal throws, tagged result pulse.
module dice_roll_scheduler
  import dice_roll_scheduler_pkg::*;
#(
  parameter int unsigned N_PLAYERS     = 4,
  parameter int unsigned ROLL_CYCLES   = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MAX_RETRY     = 3,
  localparam int unsigned PW = $clog2(N_PLAYERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PLAYERS-1:0] req,
  output logic [N_PLAYERS-1:0] grant,
  output logic                 dice_button,
  input  logic [2:0]           dice_throw,
  output logic [2:0]           result,
  output logic [PW-1:0]        result_player,
  output logic                 result_valid,
  output logic                 result_err,
  output logic                 busy
);

  localparam int unsigned CNT_MAX = (ROLL_CYCLES > SETTLE_CYCLES) ? ROLL_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned RW      = $clog2(MAX_RETRY + 2);

  localparam logic [CW-1:0] ROLL_LAST   = CW'(ROLL_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [PW-1:0] LAST_PLAYER = PW'(N_PLAYERS - 1);

  state_t                 state_q, state_d;
  logic [N_PLAYERS-1:0]   grant_q, grant_d;
  logic                   dice_button_q, dice_button_d;
  logic [2:0]             result_q, result_d;
  logic [PW-1:0]          result_player_q, result_player_d;
  logic                   result_valid_q, result_valid_d;
  logic                   result_err_q, result_err_d;
  logic                   busy_q, busy_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RW-1:0]          retry_q, retry_d;

  logic [N_PLAYERS-1:0]   arb_grant;
  logic [PW-1:0]          arb_index;
  logic                   arb_any;

  rr_arbiter #(.N_PLAYERS(N_PLAYERS)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_grant),
    .index  (arb_index),
    .any    (arb_any)
  );

  always_comb begin
    logic finish;
    finish          = 1'b0;
    state_d         = state_q;
    grant_d         = grant_q;
    result_d        = result_q;
    result_player_d = result_player_q;
    result_valid_d  = 1'b0;
    result_err_d    = result_err_q;
    rr_ptr_d        = rr_ptr_q;
    owner_d         = owner_q;
    cnt_d           = cnt_q;
    retry_d         = retry_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d = ST_ROLL;
          grant_d = arb_grant;
          owner_d = arb_index;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      ST_ROLL: begin
        if (cnt_q == ROLL_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CAPTURE: begin
        if (throw_legal(dice_throw)) begin
          finish       = 1'b1;
          result_d     = dice_throw;
          result_err_d = 1'b0;
        end else if (retry_q < RETRY_LIMIT) begin
          state_d = ST_ROLL;
          retry_d = retry_q + RW'(1);
          cnt_d   = '0;
        end else begin
          finish       = 1'b1;
          result_d     = '0;
          result_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d         = ST_IDLE;
      grant_d         = '0;
      result_valid_d  = 1'b1;
      result_player_d = owner_q;
      rr_ptr_d        = (owner_q == LAST_PLAYER) ? '0 : owner_q + PW'(1);
    end

    // Button and busy are registered copies of the next state, so they align with it.
    dice_button_d = (state_d == ST_ROLL);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      grant_q         <= '0;
      dice_button_q   <= 1'b0;
      result_q        <= '0;
      result_player_q <= '0;
      result_valid_q  <= 1'b0;
      result_err_q    <= 1'b0;
      busy_q          <= 1'b0;
      rr_ptr_q        <= '0;
      owner_q         <= '0;
      cnt_q           <= '0;
      retry_q         <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      dice_button_q   <= dice_button_d;
      result_q        <= result_d;
      result_player_q <= result_player_d;
      result_valid_q  <= result_valid_d;
      result_err_q    <= result_err_d;
      busy_q          <= busy_d;
      rr_ptr_q        <= rr_ptr_d;
      owner_q         <= owner_d;
      cnt_q           <= cnt_d;
      retry_q         <= retry_d;
    end
  end

  assign grant         = grant_q;
  assign dice_button   = dice_button_q;
  assign result        = result_q;
  assign result_player = result_player_q;
  assign result_valid  = result_valid_q;
  assign result_err    = result_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Directed bench for dice_roll_scheduler with default parameters (4 players, 8/2/3).
module tb_dice_roll_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic       dice_button;
  logic [2:0] dice_throw;
  logic [2:0] result;
  logic [1:0] result_player;
  logic       result_valid;
  logic       result_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  dice_roll_scheduler #(
    .N_PLAYERS    (4),
    .ROLL_CYCLES  (8),
    .SETTLE_CYCLES(2),
    .MAX_RETRY    (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant        (grant),
    .dice_button  (dice_button),
    .dice_throw   (dice_throw),
    .result       (result),
    .result_player(result_player),
    .result_valid (result_valid),
    .result_err   (result_err),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  initial begin
    int pulses;
    int valid_cyc;
    logic prev_btn;

    rst = 1'b1;
    req = '0;
    dice_throw = 3'd3;
    #2 rst = 1'b0;
    #1;
    chk("rst_grant",  32'(grant), 32'h0);
    chk("rst_button", 32'(dice_button), 32'h0);
    chk("rst_busy",   32'(busy), 32'h0);
    chk("rst_valid",  32'(result_valid), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    tick(2);
    rst = 1'b1;
    tick(1);

    // Reset asserted mid-roll
    req = 4'b0001;
    tick(3);
    chk("pre_rst_button", 32'(dice_button), 32'h1);
    req = '0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_button", 32'(dice_button), 32'h0);
    chk("async_rst_grant",  32'(grant), 32'h0);
    chk("async_rst_busy",   32'(busy), 32'h0);
    chk("async_rst_valid",  32'(result_valid), 32'h0);
    tick(1);
    rst = 1'b1;
    tick(2);
    chk("post_rst_idle_busy", 32'(busy), 32'h0);
    chk("post_rst_idle_btn",  32'(dice_button), 32'h0);

    // Single request from player 2
    dice_throw = 3'd3;
    req = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk($sformatf("single_grant_c%0d", k),  32'(grant), 32'h4);
      chk($sformatf("single_button_c%0d", k), 32'(dice_button), 32'h1);
      if (k == 1) req = '0;
    end
    for (int k = 9; k <= 11; k++) begin
      tick(1);
      chk($sformatf("single_btn_low_c%0d", k), 32'(dice_button), 32'h0);
      chk($sformatf("single_novalid_c%0d", k), 32'(result_valid), 32'h0);
    end
    tick(1);
    chk("single_valid",  32'(result_valid), 32'h1);
    chk("single_result", 32'(result), 32'h3);
    chk("single_player", 32'(result_player), 32'h2);
    chk("single_err",    32'(result_err), 32'h0);
    chk("single_busy",   32'(busy), 32'h0);
    chk("single_grant0", 32'(grant), 32'h0);
    dice_throw = 3'd6;
    tick(1);
    chk("single_pulse_end", 32'(result_valid), 32'h0);
    chk("single_hold",      32'(result), 32'h3);

    // Contention: all four request continuously, rr_ptr reset to 0
    pulse_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      dice_throw = 3'((t % 6) + 1);
      tick(1);
      chk($sformatf("rr_grant_t%0d", t), 32'(grant), 32'(1 << (t % 4)));
      tick(10);
      chk($sformatf("rr_grant_held_t%0d", t), 32'(grant), 32'(1 << (t % 4)));
      tick(1);
      chk($sformatf("rr_valid_t%0d", t),  32'(result_valid), 32'h1);
      chk($sformatf("rr_player_t%0d", t), 32'(result_player), 32'(t % 4));
      chk($sformatf("rr_result_t%0d", t), 32'(result), 32'((t % 6) + 1));
      chk($sformatf("rr_gap_t%0d", t),    32'(grant), 32'h0);
      if (t == 4) req = '0;
    end
    tick(1);
    chk("rr_done_busy", 32'(busy), 32'h0);

    // Illegal throw forever: 4 button pulses, error result (rr_ptr is 1 now)
    dice_throw = 3'd7;
    req = 4'b0010;
    pulses = 0;
    valid_cyc = 0;
    prev_btn = 1'b0;
    for (int k = 1; k <= 60 && valid_cyc == 0; k++) begin
      tick(1);
      if (k == 1) req = '0;
      if (dice_button && !prev_btn) pulses++;
      prev_btn = dice_button;
      if (k == 12) begin
        chk("illegal_reroll_grant",  32'(grant), 32'h2);
        chk("illegal_reroll_button", 32'(dice_button), 32'h1);
      end
      if (result_valid) begin
        valid_cyc = k;
        chk("illegal_err",    32'(result_err), 32'h1);
        chk("illegal_result", 32'(result), 32'h0);
        chk("illegal_player", 32'(result_player), 32'h1);
      end
    end
    chk("illegal_valid_cycle", 32'(valid_cyc), 32'd45);
    chk("illegal_pulses",      32'(pulses), 32'd4);

    // Recovery: throw 0 once, then 5 (rr_ptr is 2 now, player 3 requests)
    dice_throw = 3'd0;
    req = 4'b1000;
    tick(1);
    req = '0;
    chk("recov_grant", 32'(grant), 32'h8);
    tick(11);
    dice_throw = 3'd5;
    chk("recov_retry_button", 32'(dice_button), 32'h1);
    chk("recov_no_valid",     32'(result_valid), 32'h0);
    tick(11);
    chk("recov_valid",  32'(result_valid), 32'h1);
    chk("recov_result", 32'(result), 32'h5);
    chk("recov_err",    32'(result_err), 32'h0);
    chk("recov_player", 32'(result_player), 32'h3);

    // Withdrawal: winner 0 drops at cycle 3, roll still completes (rr_ptr is 0 now)
    dice_throw = 3'd4;
    req = 4'b0011;
    tick(1);
    chk("wd_grant", 32'(grant), 32'h1);
    tick(2);
    req = '0;
    tick(9);
    chk("wd_valid",  32'(result_valid), 32'h1);
    chk("wd_player", 32'(result_player), 32'h0);
    chk("wd_result", 32'(result), 32'h4);
    req = 4'b0011;
    tick(1);
    chk("wd_ptr_advanced", 32'(grant), 32'h2);
    req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
